mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter LAT_CNT_W, default 3: width of the consecutive-data-grant counter; SHALL hold STARVE_MAX.
REQ-003 CLK  in  1  system clock, all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN  in  1  instruction fetch request.
REQ-006 iaddr  in  32  instruction word address.
REQ-007 iwait  out  1  low for exactly the cycle iload is valid.
REQ-008 iload  out  32  fetched instruction.
REQ-009 dREN  in  1  data read request.
REQ-010 dWEN  in  1  data write request.
REQ-011 daddr  in  32  data word address.
REQ-012 dstore  in  32  write data.
REQ-013 dwait  out  1  low for exactly the cycle a data transaction completes.
REQ-014 dload  out  32  read data.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-021 merr  out  1  one-cycle pulse on RAM ERROR completion.

Function
REQ-022 FSM states: IDLE, IGRANT, DGRANT.
- Arbitration is evaluated only in IDLE.
REQ-023 IDLE with a data request pending (dREN|dWEN):
- Go to DGRANT if iREN=0 or dcount<STARVE_MAX.
- Otherwise go to IGRANT.
REQ-024 IDLE with only iREN pending: go to IGRANT.
- No request pending: stay in IDLE.
REQ-025 On the IDLE->grant transition, latch the following into holding registers:
- address
- store data
- operation (read/write; dWEN wins if dREN and dWEN are both high)
REQ-026 ramaddr, ramstore, ramREN and ramWEN SHALL be driven only from the holding registers.
- All four are zero in IDLE.
- Input changes during a grant SHALL NOT affect the RAM bus.
REQ-027 Latency: a request first seen in IDLE in cycle n has its RAM strobe asserted in cycle n+1.
REQ-028 Completion occurs in a grant state when ramstate=ACCESS.
- The granted side's wait goes low that cycle.
- Its load output equals ramload (data reads and instruction fetches).
- Next state is IDLE.
REQ-029 At most one wait output is low in any cycle; both are high otherwise.
REQ-030 With ramstate=ERROR in a grant state:
- Return to IDLE.
- Pulse merr for one cycle.
- Keep both waits high; the requester retries.
REQ-031 FREE or BUSY in a grant state: hold the state and the strobes.
REQ-032 dcount updates at data completion:
- Increments, saturating at STARVE_MAX, if iREN=1 in the completion cycle.
- Otherwise clears.
- dcount also clears at every instruction completion.
REQ-033 A requester dropping its request mid-grant SHALL NOT abort the RAM transaction.
- It completes normally; its wait still pulses low.
REQ-034 Back-to-back transactions have one IDLE cycle between them.
REQ-035 iload and dload SHALL hold their last value when not completing.

Reset
REQ-036 While nRST=0, asynchronously and independent of CLK:
- state=IDLE
- dcount=0
- holding registers=0
- ramREN=ramWEN=0, ramaddr=ramstore=0
- iwait=dwait=1
- iload=dload=0
- merr=0
REQ-037 Reset asserted mid-grant SHALL abandon the transaction.
- After release, arbitration restarts from IDLE with dcount=0.

Verification
REQ-038 iREN=1, iaddr=0x100, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1 from cycle 1; iwait=0 and iload=0x8C010004 in cycle 3 only.
REQ-039 iREN=dREN=1 together, daddr=0x200 -> DGRANT first (ramaddr=0x200); IGRANT follows after one IDLE cycle.
REQ-040 iREN held high with continuous dWEN, STARVE_MAX=4 -> exactly 4 data writes, then one instruction fetch, then data again.
REQ-041 dWEN=1, daddr=0x40, dstore=0xDEADBEEF; change daddr to 0x80 mid-grant -> ramaddr stays 0x40 and ramstore stays 0xDEADBEEF until ACCESS.
REQ-042 dREN grant receives ramstate=ERROR -> merr pulses once, dwait stays 1, and the request is re-granted after the next IDLE cycle.
REQ-043 nRST low during an IGRANT BUSY cycle -> ramREN=0 and iwait=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and data accesses onto one RAM port,
// data first but bounded so a waiting fetch gets through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int LAT_CNT_W  = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  localparam logic [LAT_CNT_W-1:0] SMAX = LAT_CNT_W'(STARVE_MAX);
  localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;
  state_t r_state, w_next;
  logic [LAT_CNT_W-1:0] r_dcount;
  logic [31:0] r_addr, r_store, r_iload, r_dload;
  logic r_ren, r_wen;
  logic w_dreq, w_pick_d, w_grant, w_done, w_idone, w_ddone, w_ild, w_dld;
  assign w_dreq   = dREN | dWEN;
  assign w_pick_d = w_dreq && (!iREN || r_dcount < SMAX);
  assign w_grant  = r_state != IDLE;
  assign w_done   = w_grant && ramstate == ACCESS;
  assign w_idone  = w_done && r_state == IGRANT;
  assign w_ddone  = w_done && r_state == DGRANT;
  assign w_ild    = w_idone;
  assign w_dld    = w_ddone && r_ren;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_pick_d ? DGRANT : (iREN ? IGRANT : IDLE);
    else if (ramstate == ACCESS || ramstate == ERROR) w_next = IDLE;
  end
  // Holding registers own the RAM bus; they are cleared on return to IDLE so the bus idles at zero.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
    end else if (r_state == IDLE && w_next != IDLE) begin
      r_addr  <= w_pick_d ? daddr : iaddr;
      r_store <= w_pick_d ? dstore : '0;
      r_wen   <= w_pick_d && dWEN;
      r_ren   <= !(w_pick_d && dWEN);
    end else if (w_grant && w_next == IDLE) begin
      r_addr  <= '0;
      r_store <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_dcount <= '0;
    else if (w_ddone) r_dcount <= iREN ? (r_dcount == SMAX ? SMAX : r_dcount + 1'b1) : '0;
    else if (w_idone) r_dcount <= '0;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      if (w_ild) r_iload <= ramload;
      if (w_dld) r_dload <= ramload;
    end
  assign iwait    = !w_idone;
  assign dwait    = !w_ddone;
  assign iload    = w_ild ? ramload : r_iload;
  assign dload    = w_dld ? ramload : r_dload;
  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign merr     = w_grant && ramstate == ERROR;
endmodule
